qdec_channel: RTL and testbench

QDEC_CHANNEL -- requirements
Module: qdec_channel

---
 rtl/qdec_channel.sv | 144 ++++++++++++++
 tb/tb_qdec_channel.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_channel.sv
// Quadrature decoder channel: synchronises the encoder phases and index,
// decodes legal and illegal transitions, keeps a wrapping signed position
// count, and raises a sticky error on double-phase transitions.
// Optional velocity measurement (steps per window) is compiled only when
// the macro QDEC_VELOCITY_EN is defined; otherwise velocity/vel_valid are 0.
module qdec_channel #(
   parameter int WIDTH      = 16,
   parameter int INDEX_CLR  = 1,
   parameter int VEL_PERIOD = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             quadA,
   input  logic             quadB,
   input  logic             index,
   input  logic             clear,
   input  logic             err_clr,
   output logic [WIDTH-1:0] count,
   output logic             direction,
   output logic             step,
   output logic             err,
   output logic [WIDTH-1:0] velocity,
   output logic             vel_valid
);

   if (VEL_PERIOD < 2) begin : g_bad_period
      $error("qdec_channel: VEL_PERIOD must be at least 2");
   end

   // [0] first sample, [1] current, [2] previous
   logic [2:0] a_sr;
   logic [2:0] b_sr;
   logic [2:0] idx_sr;
   logic [1:0] warm_cnt;

   logic warm_done;
   logic a_chg;
   logic b_chg;
   logic step_det;
   logic illegal_det;
   logic dir_det;
   logic idx_edge;

   // Input synchronisers; warm-up counter masks decode until the stages hold real samples
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         idx_sr   <= '0;
         warm_cnt <= '0;
      end else begin
         a_sr   <= {a_sr[1:0], quadA};
         b_sr   <= {b_sr[1:0], quadB};
         idx_sr <= {idx_sr[1:0], index};
         if (!warm_done) begin
            warm_cnt <= warm_cnt + 2'd1;
         end
      end
   end

   // Transition decode between previous and current samples
   always_comb begin
      warm_done   = (warm_cnt == 2'd3);
      a_chg       = a_sr[1] ^ a_sr[2];
      b_chg       = b_sr[1] ^ b_sr[2];
      step_det    = warm_done && (a_chg ^ b_chg);
      illegal_det = warm_done && a_chg && b_chg;
      // 00->10->11->01->00 is the up sequence
      dir_det     = a_sr[1] ^ b_sr[2];
      idx_edge    = warm_done && (INDEX_CLR != 0) && idx_sr[1] && !idx_sr[2];
   end

   // Position count (clear > index > step), step strobe, held direction, sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         direction <= 1'b0;
         step      <= 1'b0;
         err       <= 1'b0;
      end else begin
         step <= step_det;
         if (clear || idx_edge) begin
            count <= '0;
         end else if (step_det) begin
            count <= dir_det ? count + WIDTH'(1) : count - WIDTH'(1);
         end
         if (step_det) begin
            direction <= dir_det;
         end
         if (illegal_det) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

`ifdef QDEC_VELOCITY_EN
   localparam int WIN_W = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;
   localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIN_W-1:0] win_cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;

   // Saturating accumulator update including this cycle's step
   always_comb begin
      acc_next = acc;
      if (step_det) begin
         if (dir_det && (acc != ACC_MAX)) begin
            acc_next = acc + WIDTH'(1);
         end else if (!dir_det && (acc != ACC_MIN)) begin
            acc_next = acc - WIDTH'(1);
         end
      end
   end

   // Measurement window; clear and index deliberately leave it untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt   <= '0;
         acc       <= '0;
         velocity  <= '0;
         vel_valid <= 1'b0;
      end else begin
         vel_valid <= 1'b0;
         if (win_cnt == WIN_W'(VEL_PERIOD - 1)) begin
            win_cnt   <= '0;
            acc       <= '0;
            velocity  <= acc_next;
            vel_valid <= 1'b1;
         end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            acc     <= acc_next;
         end
      end
   end
`else
   assign velocity  = '0;
   assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_qdec_channel.sv
// Bench for qdec_channel: random and directed encoder motion, with a
// scoreboard of expected (count, direction) per step pulse and a
// per-window velocity model when QDEC_VELOCITY_EN is defined.
module tb_qdec_channel;

   localparam int W  = 16;
   localparam int VP = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic quadA = 1'b0, quadB = 1'b0, index = 1'b0, clear = 1'b0, err_clr = 1'b0;

   logic [W-1:0] count, count0, velocity, velocity0;
   logic direction, direction0, step, step0, err, err0, vel_valid, vel_valid0;

   qdec_channel #(.WIDTH(W), .INDEX_CLR(1), .VEL_PERIOD(VP)) dut (
      .clk(clk), .rst(rst), .quadA(quadA), .quadB(quadB), .index(index),
      .clear(clear), .err_clr(err_clr), .count(count), .direction(direction),
      .step(step), .err(err), .velocity(velocity), .vel_valid(vel_valid)
   );

   qdec_channel #(.WIDTH(W), .INDEX_CLR(0), .VEL_PERIOD(VP)) dut0 (
      .clk(clk), .rst(rst), .quadA(quadA), .quadB(quadB), .index(index),
      .clear(clear), .err_clr(err_clr), .count(count0), .direction(direction0),
      .step(step0), .err(err0), .velocity(velocity0), .vel_valid(vel_valid0)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] cnt;
      logic         dir;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp0_q[$];
   exp_t mon_e, mon_e0;

   int checks = 0;
   int passed = 0;
   int steps_seen = 0;
   int cyc = 0;
   int pos = 0;
   int win_sum[int];
   logic [W-1:0] m_count = '0;
   logic [W-1:0] m_count0 = '0;
   logic m_err = 1'b0;

   // edges since reset release
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   function automatic logic [1:0] ab_of(input int p);
      case (p & 3)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   // Reference model: one gray-code position step, expected result queued
   task automatic model_step(input bit up, input bit idx, input bit clr);
      exp_t e;
      int   w;
      int   s;
      pos = (pos + (up ? 1 : 3)) & 3;
      {quadA, quadB} = ab_of(pos);
      m_count  = clr ? '0 : idx ? '0 : (up ? m_count + 16'd1 : m_count - 16'd1);
      m_count0 = clr ? '0 : (up ? m_count0 + 16'd1 : m_count0 - 16'd1);
      e.cnt = m_count;  e.dir = up; exp_q.push_back(e);
      e.cnt = m_count0; e.dir = up; exp0_q.push_back(e);
      // input changed now is registered three edges later
      w = (cyc + 2) / VP;
      s = win_sum.exists(w) ? win_sum[w] : 0;
      s = s + (up ? 1 : -1);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      win_sum[w] = s;
   endtask

   task automatic edge_move(input bit up, input bit idx, input bit clr);
      @(negedge clk);
      model_step(up, idx, clr);
      if (idx) index = 1'b1;
      if (clr) clear = 1'b1;
      repeat (4) @(negedge clk);
      index = 1'b0;
      clear = 1'b0;
   endtask

   task automatic fast_moves(input int n, input bit up);
      repeat (n) begin
         @(negedge clk);
         model_step(up, 1'b0, 1'b0);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic bad_move();
      @(negedge clk);
      pos = (pos + 2) & 3;
      {quadA, quadB} = ab_of(pos);
      m_err = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic clear_pulse();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      m_count = '0; m_count0 = '0;
      check("clear count", count, 32'd0);
   endtask

   task automatic err_clr_pulse();
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      check("queue drained", exp_q.size(), 32'd0);
      rst = 1'b1;
      exp_q.delete(); exp0_q.delete(); win_sum.delete();
      m_count = '0; m_count0 = '0; m_err = 1'b0;
      repeat (2) @(negedge clk);
      check("reset count", count, 32'd0);
      check("reset dir/step/err", {direction, step, err}, 32'd0);
      check("reset velocity", {vel_valid, velocity}, 32'd0);
      steps_seen = 0;
      rst = 1'b0;
   endtask

   // Monitor: pop and compare on every step pulse / velocity strobe
   always @(negedge clk) begin
      if (!rst) begin
         if (step) begin
            steps_seen++;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected step: count %0h with nothing expected", count);
            end else begin
               mon_e = exp_q.pop_front();
               check("step count", count, mon_e.cnt);
               check("step dir", direction, mon_e.dir);
            end
         end
         if (step0) begin
            if (exp0_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected step0: count %0h with nothing expected", count0);
            end else begin
               mon_e0 = exp0_q.pop_front();
               check("step0 count", count0, mon_e0.cnt);
            end
         end
`ifdef QDEC_VELOCITY_EN
         if (vel_valid || (cyc > 0 && cyc % VP == 0)) begin
            check("vel_valid timing", vel_valid, (cyc > 0 && cyc % VP == 0));
            if (cyc > 0 && cyc % VP == 0)
               check("velocity", velocity,
                     W'(win_sum.exists((cyc - 1) / VP) ? win_sum[(cyc - 1) / VP] : 0));
         end
`endif
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      do_reset();
      repeat (5) @(negedge clk);

      // four forward quadrature cycles
      repeat (16) edge_move(1'b1, 1'b0, 1'b0);
      check("fwd16 count", count, 32'd16);
      check("fwd16 dir", direction, 32'd1);
      check("fwd16 err", err, 32'd0);
      check("fwd16 steps", steps_seen, 32'd16);

      // random motion with index, clear, illegal jumps and error clears
      repeat (60) begin
         r = $urandom_range(0, 9);
         if (r < 7)
            edge_move(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 7) == 0));
         else if (r < 8)
            bad_move();
         else
            err_clr_pulse();
         check("rand count", count, m_count);
         check("rand count0", count0, m_count0);
         check("rand err", err, m_err);
         check("rand err0", err0, m_err);
      end
      err_clr_pulse();

      // 0 - 1 wraps to all ones
      clear_pulse();
      edge_move(1'b0, 1'b0, 1'b0);
      check("rev wrap count", count, 32'hFFFF);
      check("rev wrap dir", direction, 32'd0);

      // index zeroes count even with a simultaneous step; INDEX_CLR=0 ignores it
      clear_pulse();
      fast_moves(100, 1'b1);
      check("at 100", count, 32'd100);
      edge_move(1'b1, 1'b1, 1'b0);
      check("index+step", count, 32'd0);
      check("index ignored", count0, 32'd101);
      edge_move(1'b1, 1'b1, 1'b1);
      check("clear+index", count, 32'd0);
      check("clear+index0", count0, 32'd0);

      // illegal transition: count held, sticky error, then cleared
      edge_move(1'b1, 1'b0, 1'b0);
      bad_move();
      check("illegal count", count, 32'd1);
      check("illegal err", err, 32'd1);
      repeat (8) @(negedge clk);
      check("err held", err, 32'd1);
      err_clr_pulse();
      check("err cleared", err, 32'd0);
      // illegal and err_clr on the same edge: illegal wins
      @(negedge clk);
      pos = (pos + 2) & 3;
      {quadA, quadB} = ab_of(pos);
      @(negedge clk);
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      check("illegal beats err_clr", err, 32'd1);
      err_clr_pulse();
      check("err cleared again", err, 32'd0);

      // min - 1 wraps to max, max + 1 wraps to min
      clear_pulse();
      fast_moves(32769, 1'b0);
      check("min wrap", count, 32'h7FFF);
      edge_move(1'b1, 1'b0, 1'b0);
      check("max wrap", count, 32'h8000);

      // inputs static at 11 across reset release
      while (pos != 2) edge_move(1'b1, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("static step/err", {step, err}, 32'd0);
         check("static count", count, 32'd0);
      end

      // velocity windows: 7 forward, then 3 reverse
      repeat (7) edge_move(1'b1, 1'b0, 1'b0);
      while (cyc < 100) @(negedge clk);
`ifdef QDEC_VELOCITY_EN
      check("window +7", {vel_valid, velocity}, {15'd0, 1'b1, 16'd7});
`else
      check("velocity tied off", {vel_valid, velocity}, 32'd0);
`endif
      repeat (3) edge_move(1'b0, 1'b0, 1'b0);
      while (cyc < 200) @(negedge clk);
`ifdef QDEC_VELOCITY_EN
      check("window -3", {vel_valid, velocity}, {15'd0, 1'b1, 16'hFFFD});
`else
      check("velocity tied off", {vel_valid, velocity}, 32'd0);
`endif
      check("final count", count, 32'd4);

      repeat (10) @(negedge clk);
      check("queue empty", exp_q.size(), 32'd0);
      check("queue0 empty", exp0_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
